// File: rtl/vip_stream_ctrl.sv
// vip_stream_ctrl: frame sequencer popping a show-ahead FIFO into a registered valid/ready pixel stream.
// Define VIP_STREAM_CTRL_ABORT_EN to add the abort input.
module vip_stream_ctrl #(
    parameter int DWIDTH = 24,
    parameter int CNT_W  = 11
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [CNT_W-1:0]  width,
    input  logic [CNT_W-1:0]  height,
    input  logic [CNT_W-1:0]  num_frame,
    input  logic              fifo_empty,
    input  logic [DWIDTH-1:0] fifo_q,
    output logic              fifo_rdreq,
    output logic [DWIDTH-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sof,
    output logic              out_eol,
    output logic              out_eof,
    output logic              busy,
    output logic              done,
`ifdef VIP_STREAM_CTRL_ABORT_EN
    input  logic              abort,
`endif
    output logic [CNT_W-1:0]  frame_cnt
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    localparam logic [CNT_W-1:0] ONE = 1;
    state_t            state_q;
    logic [CNT_W-1:0]  w_q, h_q, n_q, x_q, y_q, fcnt_q;
    logic [DWIDTH-1:0] data_q;
    logic              valid_q, sof_q, eol_q, eof_q, done_q, zpend_q;
    logic              abort_w, pop, x_last, y_last, f_last, accept, zero;
`ifdef VIP_STREAM_CTRL_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif
    assign pop    = (state_q == RUN) & !fifo_empty & (!valid_q | out_ready) & !abort_w;
    assign x_last = x_q == w_q - ONE;
    assign y_last = y_q == h_q - ONE;
    assign f_last = fcnt_q == n_q - ONE;
    // a start coinciding with done is still the tail of the previous run
    assign accept = start & (state_q == IDLE) & !done_q;
    assign zero   = (width == '0) | (height == '0) | (num_frame == '0);
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            w_q     <= '0;
            h_q     <= '0;
            n_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            fcnt_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            sof_q   <= 1'b0;
            eol_q   <= 1'b0;
            eof_q   <= 1'b0;
            done_q  <= 1'b0;
            zpend_q <= 1'b0;
        end else begin
            done_q  <= zpend_q;
            zpend_q <= 1'b0;
            if (pop) begin
                data_q  <= fifo_q;
                valid_q <= 1'b1;
                sof_q   <= (x_q == '0) & (y_q == '0);
                eol_q   <= x_last;
                eof_q   <= x_last & y_last;
            end else if (out_ready) begin
                valid_q <= 1'b0;
            end
            case (state_q)
                IDLE: if (accept) begin
                    w_q     <= width;
                    h_q     <= height;
                    n_q     <= num_frame;
                    x_q     <= '0;
                    y_q     <= '0;
                    fcnt_q  <= '0;
                    state_q <= zero ? IDLE : RUN;
                    zpend_q <= zero;
                end
                RUN: if (pop) begin
                    x_q <= x_last ? '0 : x_q + ONE;
                    if (x_last) begin
                        y_q <= y_last ? '0 : y_q + ONE;
                        if (y_last) begin
                            fcnt_q <= fcnt_q + ONE;
                            if (f_last) state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: if (valid_q & out_ready) begin
                    state_q <= IDLE;
                    done_q  <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
            if (abort_w & (state_q != IDLE)) begin
                state_q <= IDLE;
                valid_q <= 1'b0;
                x_q     <= '0;
                y_q     <= '0;
                fcnt_q  <= '0;
                done_q  <= 1'b0;
            end
        end
    end
    assign fifo_rdreq = pop;
    assign out_data   = data_q;
    assign out_valid  = valid_q;
    assign out_sof    = sof_q;
    assign out_eol    = eol_q;
    assign out_eof    = eof_q;
    assign busy       = state_q != IDLE;
    assign done       = done_q;
    assign frame_cnt  = fcnt_q;
endmodule

// File: tb/tb_vip_stream_ctrl.sv
// tb_vip_stream_ctrl: directed bench for vip_stream_ctrl with an endless incrementing FIFO model.
module tb_vip_stream_ctrl;
    localparam int DW = 24;
    localparam int CW = 11;
    logic          clock = 1'b0, reset = 1'b1, start = 1'b0, out_ready = 1'b0, hole = 1'b0;
    logic [CW-1:0] width = '0, height = '0, num_frame = '0;
    logic          fifo_empty, fifo_rdreq, out_valid, out_sof, out_eol, out_eof, busy, done;
    logic [DW-1:0] fifo_q, out_data;
    logic [CW-1:0] frame_cnt;
`ifdef VIP_STREAM_CTRL_ABORT_EN
    logic          abort = 1'b0;
`endif
    int            rd = 0, cyc = 0, n_chk = 0, n_pass = 0;
    int            n_acc, data_err, hold_err, n_done, first_acc, last_acc, done_cyc;
    logic [31:0]   sof_v, eol_v, eof_v;
    logic          pv = 1'b0, pr, ps, pe, pf;
    logic [DW-1:0] pd;

    vip_stream_ctrl #(.DWIDTH(DW), .CNT_W(CW)) dut (
        .clock(clock), .reset(reset), .start(start), .width(width), .height(height),
        .num_frame(num_frame), .fifo_empty(fifo_empty), .fifo_q(fifo_q), .fifo_rdreq(fifo_rdreq),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_sof(out_sof),
        .out_eol(out_eol), .out_eof(out_eof), .busy(busy), .done(done),
`ifdef VIP_STREAM_CTRL_ABORT_EN
        .abort(abort),
`endif
        .frame_cnt(frame_cnt)
    );

    always #5 clock = ~clock;
    assign fifo_empty = hole;
    assign fifo_q     = 24'hA00000 + DW'(rd);

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (reset) rd <= 0;
        else if (fifo_rdreq) rd <= rd + 1;
    end

    always @(negedge clock) begin
        if (reset) pv = 1'b0;
        else begin
            if (pv && !pr && (!out_valid || out_data != pd || {out_sof, out_eol, out_eof} != {ps, pe, pf}))
                hold_err++;
            if (out_valid && out_ready) begin
                if (n_acc == 0) first_acc = cyc;
                if (out_data != 24'hA00000 + DW'(n_acc)) data_err++;
                if (n_acc < 32) begin
                    sof_v[n_acc] = out_sof;
                    eol_v[n_acc] = out_eol;
                    eof_v[n_acc] = out_eof;
                end
                last_acc = cyc;
                n_acc++;
            end
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
            pv = out_valid; pr = out_ready; pd = out_data;
            ps = out_sof; pe = out_eol; pf = out_eof;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic clear();
        n_acc = 0; data_err = 0; hold_err = 0; n_done = 0;
        first_acc = -1; last_acc = -1; done_cyc = -1;
        sof_v = '0; eol_v = '0; eof_v = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; out_ready = 1'b0; hole = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        clear();
    endtask

    // ext enables the busy-latency, done-timing and start-on-done checks
    task automatic run(input string tg, input int w, input int h, input int n, input int rmode,
                       input int emode, input int mid, input bit ext, input int exp_n,
                       input logic [31:0] sm, input logic [31:0] lm, input logic [31:0] fm);
        bit got = 1'b0;
        do_reset();
        width = CW'(w); height = CW'(h); num_frame = CW'(n);
        start = 1'b1; out_ready = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        if (ext) chk({tg, "_busy_rise"}, busy, 1);
        for (int c = 0; c < 400 && !got; c++) begin
            out_ready = (rmode == 0) ? 1'b1 : c[0];
            hole      = (emode != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            start     = (c == mid);
            @(posedge clock);
            #1 start = 1'b0;
            got = done;
        end
        chk({tg, "_done_seen"}, got, 1);
        if (ext) begin
            start = 1'b1;
            @(posedge clock);
            #1 start = 1'b0;
            chk({tg, "_start_on_done"}, busy, 0);
        end
        out_ready = 1'b1; hole = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk({tg, "_count"}, n_acc, exp_n);
        chk({tg, "_pops"}, rd, exp_n);
        chk({tg, "_data_err"}, data_err, 0);
        chk({tg, "_sof"}, sof_v, sm);
        chk({tg, "_eol"}, eol_v, lm);
        chk({tg, "_eof"}, eof_v, fm);
        chk({tg, "_hold_err"}, hold_err, 0);
        chk({tg, "_frame_cnt"}, frame_cnt, n);
        chk({tg, "_done_once"}, n_done, 1);
        chk({tg, "_busy_end"}, busy, 0);
        if (ext) begin
            chk({tg, "_done_lat"}, done_cyc - last_acc, 1);
            chk({tg, "_back2back"}, last_acc - first_acc, exp_n - 1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        do_reset();
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_marks", {out_sof, out_eol, out_eof}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_fcnt", frame_cnt, 0);

        run("full", 4, 2, 2, 0, 0, -1, 1'b1, 16, 32'h0101, 32'h8888, 32'h8080);
        run("bp", 4, 2, 2, 1, 0, -1, 1'b0, 16, 32'h0101, 32'h8888, 32'h8080);
        run("empty", 4, 2, 2, 0, 1, -1, 1'b0, 16, 32'h0101, 32'h8888, 32'h8080);
        run("w1h1", 1, 1, 3, 0, 0, -1, 1'b0, 3, 32'h7, 32'h7, 32'h7);
        run("restart", 4, 2, 1, 0, 0, 3, 1'b0, 8, 32'h01, 32'h88, 32'h80);

        do_reset();
        width = '0; height = CW'(2); num_frame = CW'(1);
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        chk("zero_busy", busy, 0);
        chk("zero_done_n1", done, 0);
        @(posedge clock);
        #1;
        chk("zero_done_n2", done, 1);
        chk("zero_busy2", busy, 0);
        @(posedge clock);
        #1;
        chk("zero_done_n3", done, 0);
        chk("zero_pops", rd, 0);

`ifdef VIP_STREAM_CTRL_ABORT_EN
        do_reset();
        width = CW'(4); height = CW'(2); num_frame = CW'(1);
        out_ready = 1'b1; start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        for (int c = 0; c < 50 && n_acc < 6; c++) begin
            @(posedge clock);
            #1;
        end
        abort = 1'b1;
        @(posedge clock);
        #1 abort = 1'b0;
        chk("abort_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_fcnt", frame_cnt, 0);
        repeat (5) @(posedge clock);
        #1;
        chk("abort_no_done", n_done, 0);
        clear();
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        for (int c = 0; c < 50 && n_done == 0; c++) begin
            @(posedge clock);
            #1;
        end
        chk("abort_rerun_count", n_acc, 8);
        chk("abort_rerun_sof", sof_v, 32'h01);
        chk("abort_rerun_eof", eof_v, 32'h80);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
